// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

  localparam int          NUM_REGS   = 16;
  localparam int          REG_IDX_W  = 4;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Byte footprint of a register list: one word per set bit.
  function automatic logic [31:0] list_bytes(input logic [NUM_REGS-1:0] lst);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + {31'd0, lst[i]};
    return n * WORD_BYTES;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 plus a valid flag.
module lsb_prio_enc
  import ldm_stm_seq_pkg::*;
(
  input  logic [NUM_REGS-1:0]  vec_i,
  output logic [REG_IDX_W-1:0] idx_o,
  output logic                 valid_o
);

  // Scan high to low so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = REG_IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list in
// ascending order, one memory word per register, increment-after addressing.
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 IS_LOAD,
  input  logic [NUM_REGS-1:0]  REG_LIST,
  input  logic [31:0]          BASE_ADDR,
  output logic [REG_IDX_W-1:0] RADDR_R,
  input  logic [31:0]          RDATA,
  output logic                 W_EN,
  output logic [REG_IDX_W-1:0] RADDR_W,
  output logic [31:0]          WDATA,
  output logic                 MEM_REQ,
  output logic                 MEM_WE,
  output logic [31:0]          MEM_ADDR,
  output logic [31:0]          MEM_WDATA,
  input  logic [31:0]          MEM_RDATA,
  input  logic                 MEM_ACK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [31:0]          WB_ADDR
);

  state_e                state_q, state_d;
  logic                  is_load_q, is_load_d;
  logic [NUM_REGS-1:0]   list_q, list_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wb_q, wb_d;

  logic [REG_IDX_W-1:0]  cur_idx;
  logic                  cur_vld;
  logic [NUM_REGS-1:0]   cur_bit;
  logic                  xfer;

  lsb_prio_enc u_enc (
    .vec_i   (list_q),
    .idx_o   (cur_idx),
    .valid_o (cur_vld)
  );

  assign cur_bit = NUM_REGS'(1) << cur_idx;
  assign xfer    = (state_q == ST_XFER) && cur_vld;

  // Outputs are forced to zero outside an active transfer so idle/reset reads 0.
  assign RADDR_R   = xfer ? cur_idx : '0;
  assign RADDR_W   = xfer ? cur_idx : '0;
  assign MEM_REQ   = xfer;
  assign MEM_WE    = xfer & ~is_load_q;
  assign MEM_ADDR  = xfer ? addr_q : '0;
  assign MEM_WDATA = MEM_WE ? RDATA : '0;
  assign W_EN      = xfer & MEM_ACK & is_load_q;
  assign WDATA     = W_EN ? MEM_RDATA : '0;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_FIN);
  assign WB_ADDR   = wb_q;

  // Next-state: latch the job in IDLE, retire one register per ACK in XFER.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    list_d    = list_q;
    addr_d    = addr_q;
    wb_d      = wb_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          is_load_d = IS_LOAD;
          list_d    = REG_LIST;
          addr_d    = BASE_ADDR;
          wb_d      = BASE_ADDR + list_bytes(REG_LIST);
          state_d   = (REG_LIST == '0) ? ST_FIN : ST_XFER;
        end
      end
      ST_XFER: begin
        if (MEM_ACK) begin
          list_d = list_q & ~cur_bit;
          addr_d = addr_q + WORD_BYTES;
          if (list_d == '0) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and job registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      is_load_q <= 1'b0;
      list_q    <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      wb_q      <= wb_d;
    end
  end

endmodule
